sample_feeder: RTL and testbench
================================

Name: sample_feeder

Overview:
- Synthesizable initiator for the byte-stream interface of `sample`, i.e. the sending end of its `w`/`r`/in/out handshake.
- Holds a DATA_SIZE-byte source buffer, loaded by a host port. On `start` it streams the buffer to the downstream block and honours `r` as a stall/busy.
- Each accepted transfer captures the downstream `out` byte into a result buffer, which the host reads back afterwards.

Parameters:
- DATA_SIZE, 1024, number of bytes streamed per run
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DATA_SIZE
- DW, 8, data byte width
- TIMEOUT, 256, maximum consecutive stall cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a run (sampled only in IDLE or DONE)
- ld_we  in  1  source-buffer write enable (honoured only in IDLE or DONE)
- ld_addr  in  ADDR_W  source-buffer write address
- ld_data  in  DW  source-buffer write data
- rb_addr  in  ADDR_W  result-buffer read address
- rb_data  out  DW  result byte at rb_addr (combinational read)
- w  out  1  write strobe to downstream; high only in SEND
- r  in  1  downstream busy; 1 = stall, hold tx
- tx  out  DW  byte presented to downstream `in`
- rx  in  DW  downstream `out` byte
- busy  out  1  high in SEND
- done  out  1  high in DONE
- count  out  ADDR_W+1  number of transfers accepted in the current/last run
- err  out  1  stall timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset values: state=IDLE, w=0, tx=0, busy=0, done=0, count=0, err=0, stall counter=0. Buffers are not cleared. A reset mid-run aborts immediately; the next cycle is IDLE.
- State IDLE. If `start`=1: go to SEND, idx=0, tx<=src[0], w<=1, count<=0, err<=0. `ld_we` writes src[ld_addr]<=ld_data.
- State SEND, w=1.
  - r=1 (stall): tx, idx and count hold; no capture.
  - r=0 (accept): res[idx]<=rx, count<=count+1.
    - If idx==DATA_SIZE-1: go to DONE with w<=0, tx holds its last value.
    - Otherwise: idx<=idx+1, tx<=src[idx+1].
  - Throughput is one byte per clock when r stays 0. Run length is DATA_SIZE + (number of stall cycles) clocks from the cycle after `start`.
  - In SEND, `start` and `ld_we` are ignored and the source buffer is unchanged.
- State DONE: done=1, w=0. `start` behaves exactly as in IDLE (restarts the run). `ld_we` is honoured.
- rb_data = res[rb_addr] in every state. Reads at addresses >= DATA_SIZE return an undefined value but have no side effects.
- ld_addr >= DATA_SIZE: the write is dropped.
- The first captured rx is the byte present on the first non-stall SEND cycle, i.e. concurrent with tx=src[0]. Downstream latency is the downstream block's responsibility.
- DATA_SIZE=1 is legal: a single accept goes straight to DONE.

Optional Feature:
- Macro: SAMPLE_FEEDER_STALL_TIMEOUT_EN.
- When defined:
  - A stall counter increments on each SEND cycle with r=1 and clears on r=0.
  - When it reaches TIMEOUT: err<=1, w<=0, go to DONE, count holds the partial total.
  - err clears on `start` or rst.
- When undefined: the counter is not built, err is tied 0, and stalls may last indefinitely.

Decomposition:
- Package sample_feeder_pkg holds:
  - state enum IDLE/SEND/DONE (2-bit encoding 0/1/2)
  - default DW and ADDR_W constants
- Sub-module byte_ram (one write port, one combinational read port, DEPTH/ADDR_W/DW parameters). It is instantiated twice: source buffer and result buffer.
- FSM, index and counters stay in sample_feeder.

Test Plan:
- Load src[i]=i&0xFF for i=0..1023; tie rx=~tx; pulse start with r=0 -> w high for exactly 1024 cycles; done=1; count=1024; rb_data at addr 5 = 0xFA.
- As above with r=1 for 3 cycles when idx=10 -> tx holds 0x0A during the stall; run takes 1027 cycles; res[10]=0xF5 captured once.
- Assert rst for 1 cycle when idx=500 -> next cycle IDLE, w=0, count=0; a new start replays from src[0].
- Hold ld_we=1 with ld_addr=3, ld_data=0x55 during SEND -> src[3] unchanged; the same write in DONE -> src[3]=0x55 and is used by the next run.
- Pulse start while done=1 -> restart next cycle; count resets to 0; tx=src[0].
- With SAMPLE_FEEDER_STALL_TIMEOUT_EN and TIMEOUT=256: hold r=1 from idx=7 -> after 256 stall cycles err=1, done=1, w=0, count=7. Without the macro -> err stays 0 and w stays 1.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// sample_feeder_pkg
// Shared types and default widths for the sample_feeder byte-stream initiator.
//   state_e    : FSM state encoding (IDLE=0, SEND=1, DONE=2)
//   DEF_DW     : default data byte width
//   DEF_ADDR_W : default buffer address width
package sample_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DW     = 8;
  localparam int DEF_ADDR_W = 10;

endpackage

// File: rtl/sample_feeder_byte_ram.sv
// byte_ram
// Simple byte memory with one synchronous write port and one combinational
// read port. Used for both the source and the result buffers of sample_feeder.
// Ports:
//   clk   in  clock, rising edge
//   we    in  write enable
//   waddr in  write address (writes at or beyond DEPTH are dropped)
//   wdata in  write data
//   raddr in  read address
//   rdata out mem[raddr]; reads at or beyond DEPTH return zero
module byte_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage write; out-of-range addresses are ignored.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read with a safe value for out-of-range addresses.
  always_comb begin
    if ({1'b0, raddr} < DEPTH_L) begin
      rdata = mem_q[raddr];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// sample_feeder
// Initiator for the w/r byte-stream handshake of the downstream `sample`
// block. A host loads a DATA_SIZE-byte source buffer; `start` streams it out
// on tx with w high, stalling while r=1. Each accepted byte captures rx into
// a result buffer that the host reads back through rb_addr/rb_data.
// Optional feature macro: SAMPLE_FEEDER_STALL_TIMEOUT_EN -- aborts a run to
// DONE with err=1 after TIMEOUT consecutive stall cycles.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            begin a run (accepted in IDLE or DONE)
//   ld_we/addr/data  source-buffer load port (ignored while sending)
//   rb_addr/rb_data  result-buffer read port (combinational)
//   w, tx            write strobe and byte to downstream
//   r, rx            downstream busy and returned byte
//   busy, done       high in SEND / DONE
//   count            transfers accepted in the current/last run
//   err              stall timeout flag (0 when the feature is not built)
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DATA_SIZE = 1024,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DW        = DEF_DW,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  output logic              w,
  input  logic              r,
  output logic [DW-1:0]     tx,
  input  logic [DW-1:0]     rx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DATA_SIZE - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DW-1:0]     tx_q, tx_d;
  logic              w_q, w_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              src_we;
  logic [ADDR_W-1:0] src_raddr;
  logic [ADDR_W-1:0] idx_inc;
  logic [DW-1:0]     src_rdata;
  logic              res_we;

`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  // Last count value before the timeout fires on the next stall.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  assign idx_inc = idx_q + ADDR_W'(1);

  // Source buffer is frozen while a run is in flight.
  assign src_we = ld_we && (state_q != SEND);

  // Outside SEND the next byte needed is src[0] (for a start); inside SEND it
  // is the one after the current index (for an accept).
  assign src_raddr = (state_q == SEND) ? idx_inc : '0;

  assign res_we = (state_q == SEND) && !r;

  byte_ram #(.DEPTH(DATA_SIZE), .ADDR_W(ADDR_W), .DW(DW)) u_src_ram (
    .clk   (clk),
    .we    (src_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (src_raddr),
    .rdata (src_rdata)
  );

  byte_ram #(.DEPTH(DATA_SIZE), .ADDR_W(ADDR_W), .DW(DW)) u_res_ram (
    .clk   (clk),
    .we    (res_we),
    .waddr (idx_q),
    .wdata (rx),
    .raddr (rb_addr),
    .rdata (rb_data)
  );

  // Next-state and next-output computation for the run FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    tx_d    = tx_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          count_d = '0;
          tx_d    = src_rdata;
          w_d     = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
          stall_d = '0;
          err_d   = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end

      SEND: begin
        if (!r) begin
          count_d = count_q + (ADDR_W + 1)'(1);
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
          stall_d = '0;
`endif
          if (idx_q == LAST_IDX) begin
            // tx keeps the last byte after the run completes.
            state_d = DONE;
            w_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_inc;
            tx_d  = src_rdata;
          end
        end else begin
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
          if (stall_q == STALL_LAST) begin
            // Abort: count keeps the partial total.
            state_d = DONE;
            w_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            stall_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
`else
          // Stall: tx, index and count hold.
          state_d = state_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        w_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      tx_q    <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  end

  assign w     = w_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Testbench for sample_feeder: directed runs against a transaction-level
// model of the source/result buffers, with a per-cycle compare process.
module tb_sample_feeder;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] rb_addr = '0;
  logic [DW-1:0] rb_data;
  logic          w;
  logic          r = 1'b0;
  logic [DW-1:0] tx;
  logic [DW-1:0] rx;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err;

  // Downstream stand-in: returns the complement of what it is sent.
  assign rx = ~tx;

  always #5 clk = ~clk;

  sample_feeder #(.DATA_SIZE(N), .ADDR_W(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .w       (w),
    .r       (r),
    .tx      (tx),
    .rx      (rx),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .err     (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] src_m [N];
  bit [7:0] res_m [N];
  bit       res_v [N];
  bit       m_run = 1'b0;
  bit       m_done = 1'b0;
  bit       m_err = 1'b0;
  int       m_pos = 0;
  int       m_count = 0;
  int       m_stall = 0;
  bit [7:0] m_tx = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_count = 0; m_tx = 8'h00; m_stall = 0;
      end else if (m_run) begin
        if (!r) begin
          res_m[m_pos] = ~m_tx;
          res_v[m_pos] = 1'b1;
          m_count++;
          m_stall = 0;
          if (m_pos == N - 1) begin
            m_run = 1'b0; m_done = 1'b1;
          end else begin
            m_pos++;
            m_tx = src_m[m_pos];
          end
        end else begin
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
          m_stall++;
          if (m_stall == TO) begin
            m_run = 1'b0; m_done = 1'b1; m_err = 1'b1;
          end
`endif
        end
      end else begin
        // A start reads src[0] before any same-cycle load lands.
        if (start) begin
          m_run = 1'b1; m_done = 1'b0; m_err = 1'b0;
          m_pos = 0; m_count = 0; m_stall = 0;
          m_tx = src_m[0];
        end
        if (ld_we && int'(ld_addr) < N) src_m[ld_addr] = ld_data;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  int w_hi = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("w", w, m_run);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("tx", tx, m_tx);
        check("count", count, m_count);
        check("err", err, m_err);
        if (res_v[rb_addr]) check("rb_data", rb_data, res_m[rb_addr]);
        if (w) w_hi++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
    check("run_done", done, 1);
  endtask

  task automatic wait_pos(input int k, input int exp_tx);
    for (int i = 0; i < 3000 && !(m_run && m_pos == k); i++) @(negedge clk);
    check("reach_idx_tx", tx, exp_tx);
  endtask

  task automatic rb_check(input int addr, input int exp);
    @(negedge clk); #1 rb_addr = AW'(addr);
    @(negedge clk);
    check("rb_lit", rb_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  int w0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_w", w, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    check("rst_tx", tx, 0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Load src[i] = i & 0xFF.
    for (int i = 0; i < N; i++) begin
      @(negedge clk); #1;
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = DW'(i & 8'hFF);
    end
    @(negedge clk); #1 ld_we = 1'b0;

    // Run 1: no stalls.
    w0 = w_hi;
    pulse_start();
    wait_done();
    check("run1_wcycles", w_hi - w0, 1024);
    check("run1_count", count, 1024);
    rb_check(5, 8'hFA);

    // Run 2: three stall cycles at index 10.
    w0 = w_hi;
    pulse_start();
    wait_pos(10, 8'h0A);
    #1 r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_tx_hold", tx, 8'h0A);
    end
    #1 r = 1'b0;
    wait_done();
    check("run2_wcycles", w_hi - w0, 1027);
    rb_check(10, 8'hF5);

    // Run 3: reset mid-run at index 500, then replay.
    pulse_start();
    wait_pos(500, 8'hF4);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_w", w, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    #1 rst = 1'b0;
    pulse_start();
    check("replay_tx", tx, 8'h00);
    check("replay_w", w, 1);
    wait_done();

    // Run 4: loads during SEND are ignored, then land in DONE.
    pulse_start();
    @(negedge clk); #1;
    ld_we = 1'b1; ld_addr = AW'(3); ld_data = 8'h55;
    wait_done();
    @(negedge clk); #1 ld_we = 1'b0;
    rb_check(3, 8'hFC);

    // Run 5: restart straight from DONE uses the new src[3].
    check("pre_restart_done", done, 1);
    pulse_start();
    check("restart_count", count, 0);
    check("restart_tx", tx, 8'h00);
    check("restart_done", done, 0);
    wait_done();
    rb_check(3, 8'hAA);

    // Run 6: long stall from index 7.
    pulse_start();
    wait_pos(7, 8'h07);
    #1 r = 1'b1;
`ifdef SAMPLE_FEEDER_STALL_TIMEOUT_EN
    repeat (TO) @(negedge clk);
    check("to_err", err, 1);
    check("to_done", done, 1);
    check("to_w", w, 0);
    check("to_count", count, 7);
    #1 r = 1'b0;
    @(negedge clk);
`else
    repeat (300) @(negedge clk);
    check("nto_w", w, 1);
    check("nto_err", err, 0);
    check("nto_count", count, 7);
    #1 r = 1'b0;
    wait_done();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
